// File: rtl/reg_op_sequencer_pkg.sv
// Shared definitions for the 4004 register-class instruction sequencer:
// opcode nibbles, decoded operation kinds and the sequencer state encoding.
package reg_op_sequencer_pkg;

  localparam logic [3:0] OP_FIM_SRC = 4'h2;
  localparam logic [3:0] OP_FIN_JIN = 4'h3;
  localparam logic [3:0] OP_INC     = 4'h6;
  localparam logic [3:0] OP_ISZ     = 4'h7;
  localparam logic [3:0] OP_LD      = 4'hA;
  localparam logic [3:0] OP_XCH     = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPER,
    ST_FINRD,
    ST_ROM_WAIT,
    ST_EXEC,
    ST_ILL
  } state_e;

  typedef enum logic [3:0] {
    OPK_NONE,
    OPK_FIM,
    OPK_SRC,
    OPK_FIN,
    OPK_JIN,
    OPK_INC,
    OPK_ISZ,
    OPK_LD,
    OPK_XCH
  } op_kind_e;

  typedef struct packed {
    op_kind_e   kind;
    logic [3:0] r;
    logic [3:0] p;
    logic       needs_second;
    logic       legal;
  } decode_t;

  // Register pairs are addressed by their even member.
  function automatic logic [3:0] pair_base(input logic [3:0] r);
    return {r[3:1], 1'b0};
  endfunction

endpackage

// File: rtl/reg_op_sequencer_if.sv
// Bundle of every non-clock signal between the sequencer and its neighbours:
// instruction fetch, accumulator, registerFile, ROM and jump/SRC outputs.
interface reg_op_sequencer_if;
  import reg_op_sequencer_pkg::*;

  logic       instValid;
  logic       instReady;
  logic [7:0] instByte;
  logic [3:0] accIn;
  logic       accWe;
  logic [3:0] accDout;
  logic       regWe;
  logic [3:0] regAddr;
  logic [3:0] regDin;
  logic       pairWe;
  logic [3:0] pairAddr;
  logic [7:0] pairDin;
  logic [3:0] regDout;
  logic [7:0] pairDout;
  logic       romReq;
  logic [7:0] romAddr;
  logic       romValid;
  logic [7:0] romData;
  logic       srcValid;
  logic [7:0] srcData;
  logic       jumpValid;
  logic [7:0] jumpAddr;
  logic       done;
  logic       illegalOp;

  modport master (
    output instValid, instByte, accIn, regDout, pairDout, romValid, romData,
    input  instReady, accWe, accDout, regWe, regAddr, regDin, pairWe, pairAddr,
           pairDin, romReq, romAddr, srcValid, srcData, jumpValid, jumpAddr,
           done, illegalOp
  );

  modport slave (
    input  instValid, instByte, accIn, regDout, pairDout, romValid, romData,
    output instReady, accWe, accDout, regWe, regAddr, regDin, pairWe, pairAddr,
           pairDin, romReq, romAddr, srcValid, srcData, jumpValid, jumpAddr,
           done, illegalOp
  );

endinterface

// File: rtl/reg_op_sequencer_decode.sv
// Combinational opcode decode for the register-class instructions.
module reg_op_decode
  import reg_op_sequencer_pkg::*;
(
  input  logic [7:0] inst_byte,
  output decode_t    dec
);

  always_comb begin
    dec              = '0;
    dec.kind         = OPK_NONE;
    dec.r            = inst_byte[3:0];
    dec.p            = pair_base(inst_byte[3:0]);
    dec.needs_second = 1'b0;
    dec.legal        = 1'b1;
    case (inst_byte[7:4])
      OP_FIM_SRC: begin
        if (inst_byte[0]) begin
          dec.kind = OPK_SRC;
        end else begin
          dec.kind         = OPK_FIM;
          dec.needs_second = 1'b1;
        end
      end
      OP_FIN_JIN: begin
        if (inst_byte[0]) dec.kind = OPK_JIN;
        else              dec.kind = OPK_FIN;
      end
      OP_INC: dec.kind = OPK_INC;
      OP_ISZ: begin
        dec.kind         = OPK_ISZ;
        dec.needs_second = 1'b1;
      end
      OP_LD:  dec.kind = OPK_LD;
      OP_XCH: dec.kind = OPK_XCH;
      default: begin
        dec.kind  = OPK_NONE;
        dec.legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_op_sequencer.sv
// Sequencer for FIM/SRC/FIN/JIN/INC/ISZ/LD/XCH: accepts opcode bytes, drives
// registerFile/accumulator writes, ROM reads for FIN, and SRC/jump pulses.
module reg_op_sequencer
  import reg_op_sequencer_pkg::*;
(
  input logic               clk,
  input logic               rstN,
  reg_op_sequencer_if.slave bus
);

  decode_t dec;

  reg_op_decode u_decode (
    .inst_byte (bus.instByte),
    .dec       (dec)
  );

  state_e     state_q, state_d;
  op_kind_e   op_q, op_d;
  logic [3:0] r_q, r_d;
  logic [3:0] p_q, p_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rom_addr_q, rom_addr_d;
  logic       rom_req_q, rom_req_d;
  logic       ready_en_q, ready_en_d;

  logic       inst_ready;
  logic       inst_fire;
  logic       rom_fire;
  logic [3:0] inc_val;

  logic       acc_we;
  logic [3:0] acc_dout;
  logic       reg_we;
  logic [3:0] reg_addr;
  logic [3:0] reg_din;
  logic       pair_we;
  logic [3:0] pair_addr;
  logic [7:0] pair_din;
  logic       src_valid;
  logic [7:0] src_data;
  logic       jump_valid;
  logic [7:0] jump_addr;
  logic       done;
  logic       illegal_op;

  // ready_en_q keeps instReady low until the first edge after reset release.
  assign inst_ready = ready_en_q && ((state_q == ST_IDLE) || (state_q == ST_OPER));
  assign inst_fire  = bus.instValid && inst_ready;
  assign rom_fire   = rom_req_q && bus.romValid;
  assign inc_val    = bus.regDout + 4'd1;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= ST_IDLE;
      op_q       <= OPK_NONE;
      r_q        <= '0;
      p_q        <= '0;
      data_q     <= '0;
      rom_addr_q <= '0;
      rom_req_q  <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      r_q        <= r_d;
      p_q        <= p_d;
      data_q     <= data_d;
      rom_addr_q <= rom_addr_d;
      rom_req_q  <= rom_req_d;
      ready_en_q <= ready_en_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    r_d        = r_q;
    p_d        = p_q;
    data_d     = data_q;
    rom_addr_d = rom_addr_q;
    rom_req_d  = rom_req_q;
    ready_en_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (inst_fire) begin
          op_d = dec.kind;
          r_d  = dec.r;
          p_d  = dec.p;
          if (!dec.legal)              state_d = ST_ILL;
          else if (dec.needs_second)   state_d = ST_OPER;
          else if (dec.kind == OPK_FIN) state_d = ST_FINRD;
          else                         state_d = ST_EXEC;
        end
      end
      ST_OPER: begin
        if (inst_fire) begin
          data_d  = bus.instByte;
          state_d = ST_EXEC;
        end
      end
      ST_FINRD: begin
        rom_addr_d = bus.pairDout;
        rom_req_d  = 1'b1;
        state_d    = ST_ROM_WAIT;
      end
      ST_ROM_WAIT: begin
        if (rom_fire) begin
          data_d    = bus.romData;
          rom_req_d = 1'b0;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_IDLE;
      ST_ILL:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes/addresses come from flops; write data may follow the read-back.
  always_comb begin
    acc_we     = 1'b0;
    acc_dout   = '0;
    reg_we     = 1'b0;
    reg_addr   = '0;
    reg_din    = '0;
    pair_we    = 1'b0;
    pair_addr  = '0;
    pair_din   = '0;
    src_valid  = 1'b0;
    src_data   = '0;
    jump_valid = 1'b0;
    jump_addr  = '0;
    done       = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      ST_EXEC: begin
        done = 1'b1;
        case (op_q)
          OPK_FIM, OPK_FIN: begin
            pair_we   = 1'b1;
            pair_addr = p_q;
            pair_din  = data_q;
          end
          OPK_SRC: begin
            pair_addr = p_q;
            src_valid = 1'b1;
            src_data  = bus.pairDout;
          end
          OPK_JIN: begin
            pair_addr  = p_q;
            jump_valid = 1'b1;
            jump_addr  = bus.pairDout;
          end
          OPK_INC: begin
            reg_addr = r_q;
            reg_we   = 1'b1;
            reg_din  = inc_val;
          end
          OPK_ISZ: begin
            reg_addr = r_q;
            reg_we   = 1'b1;
            reg_din  = inc_val;
            if (inc_val != '0) begin
              jump_valid = 1'b1;
              jump_addr  = data_q;
            end
          end
          OPK_LD: begin
            reg_addr = r_q;
            acc_we   = 1'b1;
            acc_dout = bus.regDout;
          end
          OPK_XCH: begin
            reg_addr = r_q;
            reg_we   = 1'b1;
            reg_din  = bus.accIn;
            acc_we   = 1'b1;
            acc_dout = bus.regDout;
          end
          default: ;
        endcase
      end
      ST_ILL: illegal_op = 1'b1;
      default: ;
    endcase
  end

  assign bus.instReady = inst_ready;
  assign bus.accWe     = acc_we;
  assign bus.accDout   = acc_dout;
  assign bus.regWe     = reg_we;
  assign bus.regAddr   = reg_addr;
  assign bus.regDin    = reg_din;
  assign bus.pairWe    = pair_we;
  assign bus.pairAddr  = pair_addr;
  assign bus.pairDin   = pair_din;
  assign bus.romReq    = rom_req_q;
  assign bus.romAddr   = rom_addr_q;
  assign bus.srcValid  = src_valid;
  assign bus.srcData   = src_data;
  assign bus.jumpValid = jump_valid;
  assign bus.jumpAddr  = jump_addr;
  assign bus.done      = done;
  assign bus.illegalOp = illegal_op;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Scoreboard bench for reg_op_sequencer with a behavioural registerFile,
// accumulator and stalling ROM around the DUT.
module tb_reg_op_sequencer;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  reg_op_sequencer_if bus ();

  reg_op_sequencer dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_accept = 0;
  int rom_cyc  = 0;
  bit rom_hold = 1'b0;
  int rom_wait_fixed = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Environment: registerFile and accumulator updated by the DUT strobes.
  logic [3:0] rf [16] = '{default: 4'h0};
  logic [3:0] acc = 4'h0;

  always @(posedge clk) begin
    if (bus.regWe) rf[bus.regAddr] <= bus.regDin;
    if (bus.pairWe) begin
      rf[{bus.pairAddr[3:1], 1'b0}] <= bus.pairDin[7:4];
      rf[{bus.pairAddr[3:1], 1'b1}] <= bus.pairDin[3:0];
    end
    if (bus.accWe) acc <= bus.accDout;
  end

  assign bus.accIn    = acc;
  assign bus.regDout  = rf[bus.regAddr];
  assign bus.pairDout = {rf[{bus.pairAddr[3:1], 1'b0}], rf[{bus.pairAddr[3:1], 1'b1}]};

  // Reference model state.
  logic [3:0] ref_rf [16] = '{default: 4'h0};
  logic [3:0] ref_acc = 4'h0;

  typedef struct {
    bit ill, fin, reg_we, chk_ra, pair_we, chk_pa, acc_we, src_v, jump_v;
    logic [3:0] reg_addr, reg_din, pair_addr, acc_dout;
    logic [7:0] pair_din, src_d, jump_a;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] rom_exp_q [$];

  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    return (a * 8'd37) ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_issue(input logic [7:0] op, input logic [7:0] b2);
    exp_t e;
    logic [3:0] r, p, p1, v;
    logic [7:0] a, d;
    e  = '{default: '0};
    r  = op[3:0];
    p  = {op[3:1], 1'b0};
    p1 = {op[3:1], 1'b1};
    case (op[7:4])
      4'h2: begin
        e.chk_pa = 1; e.pair_addr = p;
        if (!op[0]) begin
          e.pair_we = 1; e.pair_din = b2;
          ref_rf[p] = b2[7:4]; ref_rf[p1] = b2[3:0];
        end else begin
          e.src_v = 1; e.src_d = {ref_rf[p], ref_rf[p1]};
        end
      end
      4'h3: begin
        e.chk_pa = 1; e.pair_addr = p;
        if (!op[0]) begin
          a = {ref_rf[0], ref_rf[1]};
          d = rom_fn(a);
          rom_exp_q.push_back(a);
          e.fin = 1; e.pair_we = 1; e.pair_din = d;
          ref_rf[p] = d[7:4]; ref_rf[p1] = d[3:0];
        end else begin
          e.jump_v = 1; e.jump_a = {ref_rf[p], ref_rf[p1]};
        end
      end
      4'h6, 4'h7: begin
        v = ref_rf[r] + 4'd1;
        e.reg_we = 1; e.chk_ra = 1; e.reg_addr = r; e.reg_din = v;
        ref_rf[r] = v;
        if (op[7:4] == 4'h7 && v != 4'h0) begin
          e.jump_v = 1; e.jump_a = b2;
        end
      end
      4'hA: begin
        e.acc_we = 1; e.chk_ra = 1; e.reg_addr = r; e.acc_dout = ref_rf[r];
        ref_acc = ref_rf[r];
      end
      4'hB: begin
        e.reg_we = 1; e.chk_ra = 1; e.reg_addr = r; e.reg_din = ref_acc;
        e.acc_we = 1; e.acc_dout = ref_rf[r];
        ref_acc = ref_rf[r];
        ref_rf[r] = e.reg_din;
      end
      default: e.ill = 1;
    endcase
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int n;
    ok = 0; n = 0;
    bus.instValid = 1'b1;
    bus.instByte  = b;
    while (!ok && n < 50) begin
      if (bus.instReady === 1'b1) begin
        ok = 1;
        last_accept = cyc;
      end
      @(negedge clk);
      n++;
    end
    bus.instValid = 1'b0;
    if (!ok) chk("inst_accept_timeout", 0, 1);
  endtask

  task automatic issue(input logic [7:0] op, input logic [7:0] b2, input int gap);
    bit ok;
    model_issue(op, b2);
    send_byte(op, ok);
    if (ok && (op[7:4] == 4'h7 || (op[7:4] == 4'h2 && !op[0]))) begin
      if (gap > 0) begin
        bus.instByte = 8'($urandom);
        repeat (gap) @(negedge clk);
      end
      send_byte(b2, ok);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_rf();
    drain();
    for (int i = 0; i < 16; i++) chk($sformatf("rf[%0d]", i), rf[i], ref_rf[i]);
    chk("acc", acc, ref_acc);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {bus.accWe, bus.accDout, bus.regWe, bus.regAddr, bus.regDin, bus.pairWe,
             bus.pairAddr, bus.pairDin, bus.romReq, bus.romAddr, bus.srcValid,
             bus.srcData, bus.jumpValid, bus.jumpAddr, bus.done, bus.illegalOp}, 64'h0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes an instruction.
  initial begin
    exp_t e;
    int   exp_c;
    bit   prev_done = 0;
    forever begin
      @(negedge clk);
      if (rstN) begin
        if (bus.regWe || bus.pairWe) chk("we_exclusive", bus.regWe & bus.pairWe, 0);
        chk("pairAddr_even", bus.pairAddr[0], 0);
        if (bus.done || bus.illegalOp) begin
          if (bus.done) chk("done_pulse", prev_done, 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 1, 0);
          end else begin
            e = exp_q.pop_front();
            exp_c = e.fin ? rom_cyc + 1 : last_accept + 1;
            chk("latency", cyc, exp_c);
            chk("done", bus.done, !e.ill);
            chk("illegalOp", bus.illegalOp, e.ill);
            chk("regWe", bus.regWe, e.reg_we);
            if (e.chk_ra) chk("regAddr", bus.regAddr, e.reg_addr);
            if (e.reg_we) chk("regDin", bus.regDin, e.reg_din);
            chk("pairWe", bus.pairWe, e.pair_we);
            if (e.chk_pa) chk("pairAddr", bus.pairAddr, e.pair_addr);
            if (e.pair_we) chk("pairDin", bus.pairDin, e.pair_din);
            chk("accWe", bus.accWe, e.acc_we);
            if (e.acc_we) chk("accDout", bus.accDout, e.acc_dout);
            chk("srcValid", bus.srcValid, e.src_v);
            if (e.src_v) chk("srcData", bus.srcData, e.src_d);
            chk("jumpValid", bus.jumpValid, e.jump_v);
            if (e.jump_v) chk("jumpAddr", bus.jumpAddr, e.jump_a);
          end
        end else begin
          chk("stray_strobe", {bus.regWe, bus.pairWe, bus.accWe, bus.srcValid, bus.jumpValid}, 0);
        end
        prev_done = bus.done;
      end else begin
        prev_done = 0;
      end
    end
  end

  // ROM responder: random stall, plus spurious romValid when nothing is requested.
  initial begin
    bit         prev_req = 0;
    int         rom_wait = 0;
    logic [7:0] req_addr = '0;
    bus.romValid = 1'b0;
    bus.romData  = '0;
    forever begin
      @(negedge clk);
      if (rstN && bus.romReq === 1'b1) begin
        if (!prev_req) begin
          if (rom_exp_q.size() == 0) chk("unexpected_rom_req", 1, 0);
          else chk("romAddr", bus.romAddr, rom_exp_q.pop_front());
          req_addr = bus.romAddr;
          rom_wait = (rom_wait_fixed >= 0) ? rom_wait_fixed : $urandom_range(0, 3);
        end else begin
          chk("romAddr_hold", bus.romAddr, req_addr);
        end
        if (rom_wait == 0 && !rom_hold) begin
          bus.romValid = 1'b1;
          bus.romData  = rom_fn(bus.romAddr);
          rom_cyc      = cyc;
        end else begin
          bus.romValid = 1'b0;
          if (rom_wait > 0) rom_wait--;
        end
        prev_req = 1;
      end else begin
        prev_req     = 0;
        bus.romValid = ($urandom_range(0, 5) == 0);
        bus.romData  = 8'($urandom);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [3:0] ill_hi [10] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF};

  initial begin
    bit         ok;
    int         n, k, gap, idle;
    logic [3:0] lo;
    logic [7:0] op, b2;

    bus.instValid = 1'b0;
    bus.instByte  = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    chk("reset_instReady", bus.instReady, 0);
    rstN = 1'b1;
    #1;
    chk("instReady_at_release", bus.instReady, 0);
    @(negedge clk);
    chk("instReady_after_release", bus.instReady, 1);

    issue(8'h24, 8'hA5, 0);
    check_rf();
    issue(8'h22, 8'h0F, 0);
    issue(8'h63, 8'h00, 0);
    issue(8'h22, 8'h0E, 0);
    issue(8'h73, 8'h40, 1);
    issue(8'h73, 8'h40, 0);
    check_rf();
    issue(8'h26, 8'h09, 0);
    issue(8'hA7, 8'h00, 0);
    issue(8'h26, 8'h02, 0);
    issue(8'hB7, 8'h00, 0);
    issue(8'hA7, 8'h00, 0);
    check_rf();
    issue(8'h20, 8'h12, 0);
    rom_wait_fixed = 3;
    issue(8'h36, 8'h00, 0);
    rom_wait_fixed = -1;
    issue(8'h24, 8'h5E, 0);
    issue(8'h25, 8'h00, 0);
    issue(8'h35, 8'h00, 0);
    issue(8'hD0, 8'h00, 0);
    check_rf();

    // Reset while FIN waits on ROM: no write may follow.
    rom_hold = 1'b1;
    rom_exp_q.push_back({ref_rf[0], ref_rf[1]});
    send_byte(8'h30, ok);
    n = 0;
    while (bus.romReq !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fin_romReq_seen", bus.romReq, 1);
    repeat (2) @(negedge clk);
    rstN = 1'b0;
    #1;
    chk("romReq_in_reset", bus.romReq, 0);
    chk_all_zero("midreset_outputs");
    chk("midreset_instReady", bus.instReady, 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    #1;
    chk("instReady_at_rerelease", bus.instReady, 0);
    rom_hold = 1'b0;
    @(negedge clk);
    chk("instReady_after_rerelease", bus.instReady, 1);
    repeat (3) @(negedge clk);
    check_rf();

    for (int i = 0; i < 300; i++) begin
      k  = $urandom_range(0, 8);
      lo = 4'($urandom_range(0, 15));
      case (k)
        0: op = {4'h2, lo[3:1], 1'b0};
        1: op = {4'h2, lo[3:1], 1'b1};
        2: op = {4'h3, lo[3:1], 1'b0};
        3: op = {4'h3, lo[3:1], 1'b1};
        4: op = {4'h6, lo};
        5: op = {4'h7, lo};
        6: op = {4'hA, lo};
        7: op = {4'hB, lo};
        default: op = {ill_hi[$urandom_range(0, 9)], lo};
      endcase
      b2  = 8'($urandom);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      issue(op, b2, gap);
      idle = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      if (idle > 0) repeat (idle) @(negedge clk);
    end
    check_rf();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_op_sequencer.md
Name: reg_op_sequencer

Overview:
Executes the register-class instructions of the 4004 core: FIM, SRC, FIN, JIN, INC, ISZ, LD and XCH. It sits directly upstream of registerFile, consumes fetched instruction bytes over a valid/ready handshake, and drives registerFile's write and address ports. It reads back regDout/pairDout, exchanges nibbles with the accumulator, and issues ROM reads for FIN.

Parameters:
none (widths fixed by the 4004 architecture: 16x4-bit registers, 8-bit ROM bytes)

Ports:
clk  in  1  clock
rstN  in  1  reset, asynchronous, active-low
instValid  in  1  instruction byte available
instReady  out  1  sequencer accepts byte this cycle
instByte  in  8  opcode byte, or second byte for FIM/ISZ
accIn  in  4  current accumulator value
accWe  out  1  accumulator write strobe
accDout  out  4  accumulator write data
regWe  out  1  single-register write, to registerFile
regAddr  out  4  single-register index
regDin  out  4  single-register write data
pairWe  out  1  pair write
pairAddr  out  4  pair base, always even
pairDin  out  8  pair write data, even register in [7:4]
regDout  in  4  registerFile single read
pairDout  in  8  registerFile pair read
romReq  out  1  FIN ROM read request, held until romValid
romAddr  out  8  FIN ROM address
romValid  in  1  ROM data valid
romData  in  8  ROM data
srcValid  out  1  SRC pulse
srcData  out  8  SRC pair value
jumpValid  out  1  JIN, or ISZ taken, pulse
jumpAddr  out  8  jump target low byte
done  out  1  instruction-complete pulse
illegalOp  out  1  opcode not in this block's set, pulse

Behaviour:
- Reset: state IDLE. Every output is 0 except instReady, which is 1 one cycle after release. Reset mid-instruction discards the instruction, drops romReq and performs no writes.
- Handshake: a byte transfers when instValid && instReady. instReady is 1 only in IDLE and OPER. romData transfers when romReq && romValid. romValid outside ROM_WAIT is ignored.
- Decode, latched on IDLE accept: hi=instByte[7:4], R=instByte[3:0], P={instByte[3:1],0}.
  - hi=2, R[0]=0 is FIM. hi=2, R[0]=1 is SRC.
  - hi=3, R[0]=0 is FIN. hi=3, R[0]=1 is JIN.
  - hi=6 is INC. hi=7 is ISZ. hi=A is LD. hi=B is XCH.
  - Any other opcode goes to ILL.
- States:
  - IDLE to OPER for FIM/ISZ; to FINRD for FIN; to EXEC for the others; to ILL for illegal opcodes.
  - OPER: wait for the second byte, latch it, go to EXEC.
  - FINRD: pairAddr=0. Latch pairDout into romAddr, assert romReq, go to ROM_WAIT.
  - ROM_WAIT: hold romReq and romAddr until romValid, latch romData, go to EXEC. No timeout.
  - EXEC: exactly one cycle, done=1, then IDLE.
  - ILL: illegalOp=1 and done=0 for one cycle, no writes, then IDLE.
- EXEC actions. Strobes and addresses are registered; write data may be combinational from the read-back.
  - FIM: pairWe, pairAddr=P, pairDin=second byte.
  - FIN: pairWe, pairAddr=P, pairDin=ROM byte.
  - SRC: pairAddr=P, srcValid, srcData=pairDout.
  - JIN: pairAddr=P, jumpValid, jumpAddr=pairDout.
  - INC: regAddr=R, regWe, regDin=regDout+1 mod 16 (F wraps to 0).
  - ISZ: same write as INC. If the result is not 0: jumpValid, jumpAddr=second byte. If the result is 0: no jump.
  - LD: regAddr=R, accWe, accDout=regDout. No register write.
  - XCH: regAddr=R, regWe, regDin=accIn, accWe, accDout=old regDout. Swap takes effect on one edge.
- Invariants: regWe and pairWe are never high together. pairAddr[0]=0 always. All pulses last exactly 1 cycle.
- Latency, accept at cycle T:
  - Single-byte ops: EXEC/done at T+1; next accept at T+2.
  - FIM/ISZ: second byte at T+1 earliest, done at T+2.
  - FIN: done at the romValid cycle +1.
- Inputs are held while instReady=0. Back-to-back instructions sustain one single-byte instruction per 2 cycles.

Decomposition:
- Shared package: opcode nibble constants (OP_FIM_SRC=2, OP_FIN_JIN=3, OP_INC=6, OP_ISZ=7, OP_LD=A, OP_XCH=B) and the state encoding.
- Optional sub-module reg_op_decode: combinational instByte to {opKind, R, P, needsSecondByte, legal}. The FSM stays in reg_op_sequencer.

Test Plan:
- FIM: bytes 0x24 then 0xA5 -> EXEC one cycle with pairWe=1, pairAddr=4, pairDin=A5, done=1; registerFile R4=A, R5=5.
- INC wrap / ISZ: R3=F; INC 0x63 -> regDin=0, no jump. R3=E; ISZ 0x73, 0x40 -> R3=F, jumpValid=1, jumpAddr=40. ISZ on R3=F -> R3=0, jumpValid=0, done=1.
- XCH/LD: accIn=9, R7=2; XCH 0xB7 -> R7=9, accDout=2, accWe=1. Then LD 0xA7 with R7=9 -> accDout=9, regWe=0.
- FIN with ROM stall: P0=12, FIN 0x36 -> romReq=1, romAddr=12 for 3 cycles. romValid with romData=C3 -> next cycle pairWe=1, pairAddr=6, pairDin=C3, done=1. A spurious romValid while in IDLE is ignored.
- SRC/JIN/illegal: P2 holding 5E. SRC 0x25 -> srcValid=1, srcData=5E. JIN 0x35 -> jumpValid=1, jumpAddr=5E. Opcode 0xD0 -> illegalOp=1, done=0, no strobes.
- Reset mid-FIN in ROM_WAIT: rstN=0 -> romReq=0 immediately and all outputs 0. After release, instReady=1 and no pair write occurs.
